// File: rtl/delta_seq.sv
// rtl/delta_seq.sv - microcode sequencer for the LSTM backprop gate-delta datapath
// Optional abort input is enabled by defining DELTA_SEQ_ABORT_EN.
module delta_seq #(
   parameter int N_CELL = 8,
   parameter int IDX_W  = 3
) (
   input  logic             clk,
   input  logic             rst,
`ifdef DELTA_SEQ_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] cell_idx,
   output logic             dp_clr,
   output logic             st_sel,
   output logic [1:0]       sel_in1,
   output logic [1:0]       sel_in2,
   output logic             sel_in3,
   output logic [1:0]       sel_in4,
   output logic [2:0]       sel_in5,
   output logic [1:0]       sel_x1_1,
   output logic             sel_x1_2,
   output logic [1:0]       sel_x2_2,
   output logic             sel_as_1,
   output logic [1:0]       sel_as_2,
   output logic             sel_addsub,
   output logic [1:0]       sel_temp,
   output logic             gate_vld,
   output logic [1:0]       gate_id
);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN, S_DONE} state_t;

   typedef struct packed {
      logic [1:0] in1;
      logic [1:0] in2;
      logic       in3;
      logic [1:0] in4;
      logic [2:0] in5;
      logic [1:0] x1_1;
      logic       x1_2;
      logic [1:0] x2_2;
      logic       as_1;
      logic [1:0] as_2;
      logic       addsub;
      logic [1:0] temp;
   } word_t;

   localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(N_CELL - 1);
   localparam logic [3:0]       LAST_STEP = 4'd11;

   // Fixed gate-delta schedule, one control word per RUN step.
   function automatic word_t ucode(input logic [3:0] s);
      word_t w;
      case (s)
         4'd0:    w = {2'd0, 2'd0, 1'd0, 2'd1, 3'd0, 2'd0, 1'd0, 2'd0, 1'd0, 2'd0, 1'd0, 2'd0};
         4'd2:    w = {2'd2, 2'd3, 1'd0, 2'd2, 3'd1, 2'd0, 1'd0, 2'd0, 1'd0, 2'd3, 1'd1, 2'd0};
         4'd3:    w = {2'd0, 2'd2, 1'd0, 2'd2, 3'd4, 2'd0, 1'd0, 2'd0, 1'd0, 2'd0, 1'd0, 2'd0};
         4'd4:    w = {2'd0, 2'd0, 1'd0, 2'd0, 3'd0, 2'd1, 1'd0, 2'd2, 1'd0, 2'd0, 1'd0, 2'd2};
         4'd5:    w = {2'd0, 2'd0, 1'd1, 2'd2, 3'd0, 2'd0, 1'd0, 2'd1, 1'd1, 2'd2, 1'd1, 2'd1};
         4'd6:    w = {2'd1, 2'd0, 1'd0, 2'd2, 3'd2, 2'd2, 1'd0, 2'd0, 1'd0, 2'd1, 1'd0, 2'd2};
         4'd7:    w = {2'd0, 2'd1, 1'd0, 2'd2, 3'd3, 2'd0, 1'd1, 2'd2, 1'd0, 2'd0, 1'd0, 2'd2};
         4'd8:    w = {2'd3, 2'd0, 1'd0, 2'd2, 3'd3, 2'd2, 1'd0, 2'd1, 1'd0, 2'd0, 1'd0, 2'd2};
         4'd9:    w = {2'd0, 2'd0, 1'd0, 2'd0, 3'd0, 2'd0, 1'd1, 2'd0, 1'd0, 2'd0, 1'd0, 2'd2};
         4'd10,
         4'd11:   w = {2'd0, 2'd0, 1'd0, 2'd0, 3'd0, 2'd0, 1'd0, 2'd1, 1'd0, 2'd0, 1'd0, 2'd2};
         default: w = '0;
      endcase
      return w;
   endfunction

   logic abort_w;
`ifdef DELTA_SEQ_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [3:0]       step_q, step_d;
   logic [IDX_W-1:0] cell_q, cell_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dp_clr_q, dp_clr_d;
   logic             st_sel_q, st_sel_d;
   logic             gate_vld_q, gate_vld_d;
   logic [1:0]       gate_id_q, gate_id_d;
   word_t            word_q, word_d;
   logic             last_gate;

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cell_d    = cell_q;
      last_gate = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_PRE;
               cell_d  = '0;
            end
         end
         S_PRE: begin
            if (abort_w) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RUN;
               step_d  = 4'd0;
            end
         end
         S_RUN: begin
            if (abort_w) begin
               state_d = S_IDLE;
            end else if (step_q == LAST_STEP) begin
               last_gate = 1'b1;
               if (cell_q == LAST_CELL) begin
                  state_d = S_DONE;
               end else begin
                  cell_d  = cell_q + IDX_W'(1);
                  state_d = S_PRE;
               end
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      busy_d     = (state_d == S_PRE) || (state_d == S_RUN);
      done_d     = (state_d == S_DONE);
      dp_clr_d   = (state_d == S_PRE);
      word_d     = (state_d == S_RUN) ? ucode(step_d) : '0;
      st_sel_d   = (state_d == S_RUN) && (step_d >= 4'd7);
      gate_vld_d = 1'b0;
      gate_id_d  = 2'd0;
      if (last_gate) begin
         gate_vld_d = 1'b1;
         gate_id_d  = 2'd3;
      end else if (state_d == S_RUN) begin
         case (step_d)
            4'd7:    begin gate_vld_d = 1'b1; gate_id_d = 2'd0; end
            4'd9:    begin gate_vld_d = 1'b1; gate_id_d = 2'd1; end
            4'd10:   begin gate_vld_d = 1'b1; gate_id_d = 2'd2; end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         step_q     <= 4'd0;
         cell_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dp_clr_q   <= 1'b0;
         st_sel_q   <= 1'b0;
         gate_vld_q <= 1'b0;
         gate_id_q  <= 2'd0;
         word_q     <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         cell_q     <= cell_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         dp_clr_q   <= dp_clr_d;
         st_sel_q   <= st_sel_d;
         gate_vld_q <= gate_vld_d;
         gate_id_q  <= gate_id_d;
         word_q     <= word_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign cell_idx   = cell_q;
   assign dp_clr     = dp_clr_q;
   assign st_sel     = st_sel_q;
   assign gate_vld   = gate_vld_q;
   assign gate_id    = gate_id_q;
   assign sel_in1    = word_q.in1;
   assign sel_in2    = word_q.in2;
   assign sel_in3    = word_q.in3;
   assign sel_in4    = word_q.in4;
   assign sel_in5    = word_q.in5;
   assign sel_x1_1   = word_q.x1_1;
   assign sel_x1_2   = word_q.x1_2;
   assign sel_x2_2   = word_q.x2_2;
   assign sel_as_1   = word_q.as_1;
   assign sel_as_2   = word_q.as_2;
   assign sel_addsub = word_q.addsub;
   assign sel_temp   = word_q.temp;

endmodule

// File: tb/tb_delta_seq.sv
// tb/tb_delta_seq.sv - self-checking bench for delta_seq (N_CELL=1 and N_CELL=3 instances)
// Abort scenarios are exercised when DELTA_SEQ_ABORT_EN is defined.
module tb_delta_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic abort_s = 1'b0;

   always #5 clk = ~clk;

   // Select field order: in1 in2 in3 in4 in5 x1_1 x1_2 x2_2 as_1 as_2 addsub temp
   wire [20:0] w1, w3;
   wire        b1, d1, clr1, st1, gv1;
   wire        b3, d3, clr3, st3, gv3;
   wire [0:0]  c1;
   wire [1:0]  c3;
   wire [1:0]  gi1, gi3;

   delta_seq #(.N_CELL(1), .IDX_W(1)) u1 (
      .clk(clk), .rst(rst),
`ifdef DELTA_SEQ_ABORT_EN
      .abort(abort_s),
`endif
      .start(start), .busy(b1), .done(d1), .cell_idx(c1), .dp_clr(clr1), .st_sel(st1),
      .sel_in1(w1[20:19]), .sel_in2(w1[18:17]), .sel_in3(w1[16]), .sel_in4(w1[15:14]),
      .sel_in5(w1[13:11]), .sel_x1_1(w1[10:9]), .sel_x1_2(w1[8]), .sel_x2_2(w1[7:6]),
      .sel_as_1(w1[5]), .sel_as_2(w1[4:3]), .sel_addsub(w1[2]), .sel_temp(w1[1:0]),
      .gate_vld(gv1), .gate_id(gi1));

   delta_seq #(.N_CELL(3), .IDX_W(2)) u3 (
      .clk(clk), .rst(rst),
`ifdef DELTA_SEQ_ABORT_EN
      .abort(abort_s),
`endif
      .start(start), .busy(b3), .done(d3), .cell_idx(c3), .dp_clr(clr3), .st_sel(st3),
      .sel_in1(w3[20:19]), .sel_in2(w3[18:17]), .sel_in3(w3[16]), .sel_in4(w3[15:14]),
      .sel_in5(w3[13:11]), .sel_x1_1(w3[10:9]), .sel_x1_2(w3[8]), .sel_x2_2(w3[7:6]),
      .sel_as_1(w3[5]), .sel_as_2(w3[4:3]), .sel_addsub(w3[2]), .sel_temp(w3[1:0]),
      .gate_vld(gv3), .gate_id(gi3));

   localparam int WT [12][12] = '{
      '{0,0,0,1,0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0,0,0,0,0},
      '{2,3,0,2,1,0,0,0,0,3,1,0}, '{0,2,0,2,4,0,0,0,0,0,0,0},
      '{0,0,0,0,0,1,0,2,0,0,0,2}, '{0,0,1,2,0,0,0,1,1,2,1,1},
      '{1,0,0,2,2,2,0,0,0,1,0,2}, '{0,1,0,2,3,0,1,2,0,0,0,2},
      '{3,0,0,2,3,2,0,1,0,0,0,2}, '{0,0,0,0,0,0,1,0,0,0,0,2},
      '{0,0,0,0,0,0,0,1,0,0,0,2}, '{0,0,0,0,0,0,0,1,0,0,0,2}};

   // Model: mk = cycles since accepted start (0 = idle), 13 cycles per cell, then DONE.
   int mk [2];
   int mc [2];
   int ncell [2] = '{1, 3};

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            mk[i] <= 0;
            mc[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (mk[i] == 0) begin
               if (start) begin
                  mk[i] <= 1;
                  mc[i] <= 0;
               end
            end else if (abort_s && mk[i] <= 13 * ncell[i]) begin
               mk[i] <= 0;
            end else if (mk[i] == 13 * ncell[i] + 1) begin
               mk[i] <= 0;
            end else begin
               mk[i] <= mk[i] + 1;
               if (mk[i] < 13 * ncell[i]) mc[i] <= mk[i] / 13;
            end
         end
      end
   end

   function automatic logic [20:0] pack_w(input int s);
      return {2'(WT[s][0]), 2'(WT[s][1]), 1'(WT[s][2]), 2'(WT[s][3]), 3'(WT[s][4]),
              2'(WT[s][5]), 1'(WT[s][6]), 2'(WT[s][7]), 1'(WT[s][8]), 2'(WT[s][9]),
              1'(WT[s][10]), 2'(WT[s][11])};
   endfunction

   // [30] busy [29] done [28:26] cell [25] dp_clr [24] st_sel [23] gate_vld [22:21] gate_id [20:0] selects
   function automatic logic [30:0] exp_vec(input int k, input int n, input int c);
      logic [30:0] v;
      int p, s;
      v = '0;
      v[28:26] = 3'(c);
      if (k >= 1 && k <= 13 * n) begin
         v[30] = 1'b1;
         p = (k - 1) % 13;
         if (p == 0) begin
            v[25] = 1'b1;
            if (k > 1) v[23:21] = 3'b111;
         end else begin
            s = p - 1;
            v[20:0] = pack_w(s);
            v[24] = (s >= 7);
            if (s == 7)  v[23:21] = 3'b100;
            if (s == 9)  v[23:21] = 3'b101;
            if (s == 10) v[23:21] = 3'b110;
         end
      end else if (k == 13 * n + 1) begin
         v[29] = 1'b1;
         v[23:21] = 3'b111;
      end
      return v;
   endfunction

   logic [30:0] act1, act3;
   assign act1 = {b1, d1, 2'b00, c1, clr1, st1, gv1, gv1 ? gi1 : 2'b00, w1};
   assign act3 = {b3, d3, 1'b0, c3, clr3, st3, gv3, gv3 ? gi3 : 2'b00, w3};

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      check("model_n1", {1'b0, act1}, {1'b0, exp_vec(mk[0], 1, mc[0])});
      check("model_n3", {1'b0, act3}, {1'b0, exp_vec(mk[1], 3, mc[1])});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_k(input int i, input int val, input int lim);
      for (int t = 0; t < lim && mk[i] != val; t++) tick();
      if (mk[i] != val) check("wait_timeout", 32'(mk[i]), 32'(val));
   endtask

   int busy1, busy3, str1, str3, done_at1, done_at3, dn1, dn3;
   logic [7:0]  ids1;
   logic [5:0]  cells3;
   logic [20:0] w_step2, w_step3;

   initial begin
      tick();
      tick();
      check("reset_outputs", {1'b0, act3}, 32'd0);
      rst = 1'b1;
      repeat (3) tick();

      // Reset mid-run at step 5 of cell 0
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_k(1, 7, 20);
      #2 rst = 1'b0;
      #1;
      check("async_reset_n3", {1'b0, act3}, 32'd0);
      check("async_reset_n1", {1'b0, act1}, 32'd0);
      tick();
      rst = 1'b1;
      repeat (5) tick();
      check("idle_after_reset", {1'b0, act3}, 32'd0);

      // Single pulse: both instances run from the same start
      busy1 = 0; busy3 = 0; str1 = 0; str3 = 0; done_at1 = 0; done_at3 = 0;
      ids1 = '0; cells3 = '0; w_step2 = '0; w_step3 = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 50; c++) begin
         if (b1) busy1++;
         if (b3) busy3++;
         if (gv1) begin str1++; ids1 = {ids1[5:0], gi1}; end
         if (gv3) str3++;
         if (d1 && done_at1 == 0) done_at1 = c;
         if (d3 && done_at3 == 0) done_at3 = c;
         if (c == 4) w_step2 = w1;
         if (c == 5) w_step3 = w1;
         if (c == 2)  cells3[5:4] = c3;
         if (c == 15) cells3[3:2] = c3;
         if (c == 28) cells3[1:0] = c3;
         tick();
      end
      check("done_cycle_n1", 32'(done_at1), 32'd14);
      check("done_cycle_n3", 32'(done_at3), 32'd40);
      check("busy_cycles_n1", 32'(busy1), 32'd13);
      check("busy_cycles_n3", 32'(busy3), 32'd39);
      check("strobes_n1", 32'(str1), 32'd4);
      check("strobes_n3", 32'(str3), 32'd12);
      check("gate_id_order", 32'(ids1), 32'h1B);
      check("step2_in2", 32'(w_step2[18:17]), 32'd3);
      check("step2_as2", 32'(w_step2[4:3]), 32'd3);
      check("step3_in5", 32'(w_step3[13:11]), 32'd4);
      check("cell_sequence", 32'(cells3), 32'b00_01_10);
      check("cell_hold", 32'(c3), 32'd2);

      // start held until the N_CELL=3 run reports done
      dn1 = 0; dn3 = 0;
      start = 1'b1;
      for (int c = 1; c <= 45; c++) begin
         if (d1) dn1++;
         if (d3) begin dn3++; start = 1'b0; end
         tick();
      end
      start = 1'b0;
      check("held_start_runs_n3", 32'(dn3), 32'd1);
      check("held_start_runs_n1", 32'(dn1), 32'd3);
      check("held_start_idle", 32'(b3), 32'd0);
      wait_k(0, 0, 40);
      wait_k(1, 0, 60);

`ifdef DELTA_SEQ_ABORT_EN
      // Abort at step 8 of cell 1, then restart from cell 0
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_k(1, 23, 40);
      abort_s = 1'b1;
      tick();
      abort_s = 1'b0;
      check("abort_outputs", {1'b0, act3[30:29], act3[25:0]}, 32'd0 | (32'(c3) << 26) >> 0 & 32'h0);
      dn3 = 0; str3 = 0;
      for (int c = 0; c < 20; c++) begin
         if (d3) dn3++;
         if (gv3) str3++;
         tick();
      end
      check("abort_no_done", 32'(dn3), 32'd0);
      check("abort_no_strobe", 32'(str3), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_cell0", 32'(c3), 32'd0);
      check("restart_busy", 32'(b3), 32'd1);
`endif

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 15) == 0);
`ifdef DELTA_SEQ_ABORT_EN
         abort_s = ($urandom_range(0, 63) == 0);
`endif
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b0;
            tick();
            rst = 1'b1;
         end else begin
            tick();
         end
      end
      start = 1'b0;
      abort_s = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
